// File: rtl/link_pkg.sv
// link_pkg: shared state encoding, default ACK byte and command
// constants for the inter-FPGA UART command link.
package link_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        SENDING   = 3'd2,
        WAIT_RESP = 3'd3,
        RETRY     = 3'd4,
        RESULT    = 3'd5
    } link_state_e;

    localparam logic [7:0] ACK_DEFAULT = 8'h3C;

    localparam logic [3:0] TURN_ON  = 4'h6;
    localparam logic [3:0] TURN_OFF = 4'hD;
    localparam logic [7:0] TOGGLE   = 8'h9D;

endpackage

// File: rtl/hamming_7_4_encoder.sv
// hamming_7_4_encoder: combinational Hamming(7,4) encoder,
// code word laid out as {d3,d2,d1,p3,d0,p2,p1}.
module hamming_7_4_encoder (
    input  logic [3:0] data_i,
    output logic [6:0] code_o
);

    logic p1;
    logic p2;
    logic p3;

    assign p1 = data_i[0] ^ data_i[1] ^ data_i[3];
    assign p2 = data_i[0] ^ data_i[2] ^ data_i[3];
    assign p3 = data_i[1] ^ data_i[2] ^ data_i[3];

    assign code_o = {data_i[3], data_i[2], data_i[1], p3,
                     data_i[0], p2, p1};

endmodule

// File: rtl/uart_cmd_link.sv
// uart_cmd_link: sends one command byte over uart_tx and waits for an ACK,
// retrying on NACK/timeout. Define UART_CMD_LINK_HAMMING_EN to Hamming-encode.
module uart_cmd_link
    import link_pkg::*;
#(
    parameter logic [7:0]  ACK_BYTE         = ACK_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES   = 48000,
    parameter int unsigned BUSY_WAIT_CYCLES = 64,
    parameter int unsigned MAX_RETRIES      = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    input  logic       rx_parity_error,
    output logic       done,
    output logic       ok,
    output logic       err_nack,
    output logic       err_timeout,
    output logic       err_tx,
    output logic [3:0] attempts
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW = $clog2(BUSY_WAIT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [BW-1:0] BUSY_LAST = BW'(BUSY_WAIT_CYCLES - 1);
    localparam logic [4:0]    RETRY_LIM = 5'(MAX_RETRIES);

    link_state_e   state_q, state_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [BW-1:0] bsy_q, bsy_d;
    logic          rdy_q, rdy_d;
    logic          start_q, start_d;
    logic [7:0]    txd_q, txd_d;
    logic          done_q, done_d;
    logic          ok_q, ok_d;
    logic          enak_q, enak_d;
    logic          etmo_q, etmo_d;
    logic          etx_q, etx_d;
    logic [3:0]    att_q, att_d;
    logic [7:0]    enc_data;

`ifdef UART_CMD_LINK_HAMMING_EN
    logic [6:0] code;

    hamming_7_4_encoder u_ham (
        .data_i (cmd_data[3:0]),
        .code_o (code)
    );

    assign enc_data = {1'b1, code};
`else
    assign enc_data = cmd_data;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        bsy_d   = bsy_q;
        rdy_d   = 1'b0;
        start_d = start_q;
        txd_d   = txd_q;
        done_d  = 1'b0;
        ok_d    = ok_q;
        enak_d  = enak_q;
        etmo_d  = etmo_q;
        etx_d   = etx_q;
        unique case (state_q)
            IDLE: begin
                rdy_d = 1'b1;
                if (cmd_valid && rdy_q) begin
                    state_d = START;
                    rdy_d   = 1'b0;
                    start_d = 1'b1;
                    txd_d   = enc_data;
                    cnt_d   = 5'd1;
                    bsy_d   = '0;
                    ok_d    = 1'b0;
                    enak_d  = 1'b0;
                    etmo_d  = 1'b0;
                    etx_d   = 1'b0;
                end
            end
            START: begin
                if (tx_busy) begin
                    state_d = SENDING;
                    start_d = 1'b0;
                end else if (bsy_q == BUSY_LAST) begin
                    state_d = RETRY;
                    start_d = 1'b0;
                    enak_d  = 1'b0;
                    etmo_d  = 1'b0;
                    etx_d   = 1'b1;
                end else begin
                    bsy_d = bsy_q + 1'b1;
                end
            end
            SENDING: begin
                if (!tx_busy) begin
                    state_d = WAIT_RESP;
                    tmo_d   = '0;
                end
            end
            WAIT_RESP: begin
                // A response arriving on the timeout cycle still counts.
                if (rx_done) begin
                    if (rx_data == ACK_BYTE && !rx_parity_error) begin
                        state_d = RESULT;
                        done_d  = 1'b1;
                        ok_d    = 1'b1;
                    end else begin
                        state_d = RETRY;
                        enak_d  = 1'b1;
                        etmo_d  = 1'b0;
                        etx_d   = 1'b0;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = RETRY;
                    enak_d  = 1'b0;
                    etmo_d  = 1'b1;
                    etx_d   = 1'b0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            RETRY: begin
                if (cnt_q <= RETRY_LIM) begin
                    state_d = START;
                    start_d = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    bsy_d   = '0;
                end else begin
                    state_d = RESULT;
                    done_d  = 1'b1;
                    ok_d    = 1'b0;
                end
            end
            RESULT: begin
                state_d = IDLE;
                rdy_d   = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        att_d = (cnt_d > 5'd15) ? 4'hF : cnt_d[3:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tmo_q   <= '0;
            bsy_q   <= '0;
            rdy_q   <= 1'b0;
            start_q <= 1'b0;
            txd_q   <= '0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            enak_q  <= 1'b0;
            etmo_q  <= 1'b0;
            etx_q   <= 1'b0;
            att_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            bsy_q   <= bsy_d;
            rdy_q   <= rdy_d;
            start_q <= start_d;
            txd_q   <= txd_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            enak_q  <= enak_d;
            etmo_q  <= etmo_d;
            etx_q   <= etx_d;
            att_q   <= att_d;
        end
    end

    assign cmd_ready   = rdy_q;
    assign tx_start    = start_q;
    assign tx_data     = txd_q;
    assign done        = done_q;
    assign ok          = ok_q;
    assign err_nack    = enak_q;
    assign err_timeout = etmo_q;
    assign err_tx      = etx_q;
    assign attempts    = att_q;

endmodule

// File: tb/tb_uart_cmd_link.sv
// tb_uart_cmd_link: randomized UART responder plus an attempt-outcome
// reference model for uart_cmd_link.
module tb_uart_cmd_link;
    import link_pkg::*;

    localparam int TMO    = 300;
    localparam int BUSY_W = 16;
    localparam int MAX_R  = 3;
    localparam logic [7:0] ACK = 8'h3C;

    localparam int K_ACK = 0;
    localparam int K_NAK = 1;
    localparam int K_PAR = 2;
    localparam int K_TMO = 3;
    localparam int K_TXF = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_data = '0;
    logic       cmd_ready;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy = 1'b0;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_parity_error = 1'b0;
    logic       done;
    logic       ok;
    logic       err_nack;
    logic       err_timeout;
    logic       err_tx;
    logic [3:0] attempts;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_cnt = 0;

    int pk[16];
    int pd[16];
    int pl[16];
    int pr[16];
    int ps[16];
    logic [7:0] pb[16];

    uart_cmd_link #(
        .ACK_BYTE         (ACK),
        .TIMEOUT_CYCLES   (TMO),
        .BUSY_WAIT_CYCLES (BUSY_W),
        .MAX_RETRIES      (MAX_R)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_data        (cmd_data),
        .cmd_ready       (cmd_ready),
        .tx_start        (tx_start),
        .tx_data         (tx_data),
        .tx_busy         (tx_busy),
        .rx_done         (rx_done),
        .rx_data         (rx_data),
        .rx_parity_error (rx_parity_error),
        .done            (done),
        .ok              (ok),
        .err_nack        (err_nack),
        .err_timeout     (err_timeout),
        .err_tx          (err_tx),
        .attempts        (attempts)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] enc(input logic [7:0] b);
`ifdef UART_CMD_LINK_HAMMING_EN
        return {1'b1, b[3], b[2], b[1], b[1] ^ b[2] ^ b[3],
                b[0], b[0] ^ b[2] ^ b[3], b[0] ^ b[1] ^ b[3]};
`else
        return b;
`endif
    endfunction

    task automatic set_plan(input int i, input int k, input int d,
                            input int l, input int r);
        pk[i] = k;
        pd[i] = d;
        pl[i] = l;
        pr[i] = r;
        ps[i] = 0;
        pb[i] = 8'h55;
    endtask

    task automatic clear_plan;
        for (int i = 0; i < 16; i++) set_plan(i, K_ACK, 1, 3, 1);
    endtask

    task automatic rand_plan;
        int r;
        int k;
        logic [7:0] v;
        for (int i = 0; i < 16; i++) begin
            r = $urandom_range(0, 9);
            k = (r < 4) ? K_ACK : (r < 6) ? K_NAK : (r < 7) ? K_PAR :
                (r < 8) ? K_TMO : (r < 9) ? K_TXF : K_ACK;
            set_plan(i, k, $urandom_range(0, 5), $urandom_range(1, 20),
                     $urandom_range(0, 40));
            ps[i] = $urandom_range(0, 1);
            v = 8'($urandom);
            while (v == ACK) v = 8'($urandom);
            pb[i] = v;
        end
    endtask

    task automatic run_cmd(input logic [7:0] b);
        int a, n, k, att, c, dc0, e_att, last;
        logic fin, e_ok;
        logic [2:0] e_err;
        logic [7:0] etx;
        etx = enc(b);
        e_att = 0;
        e_ok = 1'b0;
        last = -1;
        for (int i = 0; i <= MAX_R; i++) begin
            e_att++;
            if (pk[i] == K_ACK) begin
                e_ok = 1'b1;
                break;
            end
            last = pk[i];
        end
        e_err = {last == K_NAK || last == K_PAR, last == K_TMO,
                 last == K_TXF};

        n = 0;
        while (!cmd_ready && n < 100) begin
            tick;
            n++;
        end
        check("ready_wait", 32'(cmd_ready), 1);
        dc0 = done_cnt;
        cmd_valid = 1'b1;
        cmd_data = b;
        a = cyc;
        tick;
        cmd_valid = 1'b0;
        cmd_data = 8'($urandom);
        check("start_lat", 32'(tx_start), 1);
        check("ready_drop", 32'(cmd_ready), 0);

        att = 0;
        fin = 1'b0;
        while (!fin) begin
            k = pk[att];
            c = 0;
            check("tx_data", 32'(tx_data), 32'(etx));
            if (k == K_TXF) begin
                n = 0;
                while (tx_start && n < BUSY_W + 8) begin
                    tick;
                    n++;
                end
                check("busy_win", n, BUSY_W);
            end else begin
                repeat (pd[att]) tick;
                tx_busy = 1'b1;
                tick;
                check("start_drop", 32'(tx_start), 0);
                if (pl[att] >= 2 && ps[att] != 0) begin
                    rx_done = 1'b1;
                    rx_data = ACK;
                    cmd_valid = 1'b1;
                    tick;
                    rx_done = 1'b0;
                    cmd_valid = 1'b0;
                    repeat (pl[att] - 2) tick;
                end else begin
                    repeat (pl[att] - 1) tick;
                end
                tx_busy = 1'b0;
                c = cyc;
                tick;
                if (k != K_TMO) begin
                    repeat (pr[att]) tick;
                    rx_done = 1'b1;
                    rx_data = (k == K_NAK) ? pb[att] : ACK;
                    rx_parity_error = (k == K_PAR);
                    tick;
                    rx_done = 1'b0;
                    rx_parity_error = 1'b0;
                end
            end
            att++;
            fin = (k == K_ACK) || (att == MAX_R + 1);
            n = 0;
            while (!(fin ? done : tx_start) && n < TMO + 100) begin
                tick;
                n++;
            end
            check("event_wait", 32'(n < TMO + 100), 1);
            if (n >= TMO + 100) fin = 1'b1;
            // WAIT_RESP lasts TMO cycles, framed by the hand-off cycles
            if (k == K_TMO) check("tmo_gap", cyc - c, TMO + 2);
        end

        check("lat_min", 32'((cyc - a) >= 4), 1);
        check("ok", 32'(ok), 32'(e_ok));
        check("attempts", 32'(attempts), e_att);
        check("errs", 32'({err_nack, err_timeout, err_tx}), 32'(e_err));
        tick;
        check("done_1cyc", 32'(done), 0);
        check("ready_after", 32'(cmd_ready), 1);
        check("hold", 32'({ok, err_nack, err_timeout, err_tx, attempts}),
              32'({e_ok, e_err, 4'(e_att)}));
        check("done_cnt", done_cnt - dc0, 1);
        rx_done = 1'b1;
        rx_data = ACK;
        tick;
        rx_done = 1'b0;
        tick;
        check("idle_quiet", 32'({tx_start, done, cmd_ready}), 32'(3'b001));
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, 32'({cmd_ready, tx_start, tx_data, done, ok, err_nack,
                        err_timeout, err_tx, attempts}), 0);
    endtask

    initial begin
        int dc0;
        clear_plan;
        repeat (3) tick;
        check_all_zero("reset_outs");
        reset = 1'b1;
        tick;
        check("ready_post_rst", 32'(cmd_ready), 1);
        check("start_post_rst", 32'(tx_start), 0);

        clear_plan;
        set_plan(0, K_ACK, 2, 480, 3);
        run_cmd(TOGGLE);

        clear_plan;
        for (int i = 0; i <= MAX_R; i++) set_plan(i, K_TMO, 1, 5, 0);
        run_cmd(8'hA5);

        clear_plan;
        set_plan(0, K_NAK, 0, 3, 4);
        set_plan(1, K_ACK, 1, 3, 2);
        run_cmd(8'h12);

        clear_plan;
        set_plan(0, K_PAR, 0, 4, 1);
        ps[0] = 1;
        set_plan(1, K_ACK, 0, 2, 0);
        run_cmd(8'h77);

        clear_plan;
        set_plan(0, K_ACK, 0, 1, 0);
        run_cmd({4'h0, TURN_ON});

        clear_plan;
        set_plan(0, K_TXF, 0, 1, 0);
        set_plan(1, K_ACK, 3, 6, 5);
        run_cmd({4'h0, TURN_OFF});

        clear_plan;
        run_cmd(8'hF6);

        clear_plan;
        cmd_valid = 1'b1;
        cmd_data = TOGGLE;
        tick;
        cmd_valid = 1'b0;
        tx_busy = 1'b1;
        repeat (4) tick;
        tx_busy = 1'b0;
        repeat (12) tick;
        dc0 = done_cnt;
        reset = 1'b0;
        tick;
        check_all_zero("abort_outs");
        repeat (3) tick;
        check_all_zero("abort_hold");
        reset = 1'b1;
        tick;
        check("abort_ready", 32'(cmd_ready), 1);
        check("abort_nodone", done_cnt - dc0, 0);
        run_cmd(8'h3A);

        for (int t = 0; t < 25; t++) begin
            rand_plan;
            run_cmd(8'($urandom));
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_cmd_link.md
# uart_cmd_link

Master-side command controller for the inter-FPGA UART link. It accepts one command byte at a time from the control logic and sequences the existing `uart_tx`/`uart_rx` pair: it starts the transmit, waits for the byte to leave, then waits for an acknowledge byte, retrying on timeout or NACK. It sits between the SPWM/shoot control FSM in the top and the UART datapath, replacing ad-hoc per-top send/wait state machines.

## Interface
Parameters:
- `ACK_BYTE`, 8'h3C: response byte that counts as success.
- `TIMEOUT_CYCLES`, 48000: response window in `clk` cycles (1 ms at 48 MHz). Must be ≥ 1.
- `BUSY_WAIT_CYCLES`, 64: maximum cycles from `tx_start` assertion to `tx_busy` rising.
- `MAX_RETRIES`, 3: retransmissions after the first attempt. Range 0–15.

Ports:
- `clk` in 1: 48 MHz HFOSC clock.
- `reset` in 1: synchronous, active-low.
- `cmd_valid` in 1, `cmd_data` in 8, `cmd_ready` out 1: command handshake.
- `tx_start` out 1, `tx_data` out 8, `tx_busy` in 1: connect to `uart_tx`.
- `rx_done` in 1, `rx_data` in 8, `rx_parity_error` in 1: connect to `uart_rx`.
- `done` out 1: one-cycle pulse that ends every accepted command.
- `ok` out 1: valid with `done`. 1 means the ACK was received.
- `err_nack` out 1, `err_timeout` out 1, `err_tx` out 1: valid with `done`, identifying the cause of the last failed attempt.
- `attempts` out 4: number of transmissions made, valid with `done`.

## Operation
- All outputs are registered. While `reset` is 0, every output is 0 and the state is IDLE. `cmd_ready` goes to 1 on the first cycle after reset is released.
- **IDLE**: `cmd_ready`=1. When `cmd_valid`&&`cmd_ready`, the block latches `cmd_data`, clears `attempts`, drops `cmd_ready` and goes to START.
- **START**: `tx_start`=1, `tx_data`=encoded byte, and `attempts` increments on entry. `tx_start` stays high until `tx_busy`=1 is seen; the block then goes to SENDING with `tx_start`=0. If `tx_busy` does not rise within `BUSY_WAIT_CYCLES`, the attempt fails with `err_tx` and goes to RETRY.
- **SENDING**: the block waits for `tx_busy`=0, then goes to WAIT_RESP and clears the timeout counter.
- **WAIT_RESP**:
  - `rx_done` with `rx_data`==`ACK_BYTE` and `rx_parity_error`=0 → RESULT with `ok`=1.
  - `rx_done` with any other byte, or with a parity error → `err_nack`, go to RETRY.
  - The counter reaches `TIMEOUT_CYCLES` → `err_timeout`, go to RETRY.
  - If `rx_done` and the timeout occur in the same cycle, `rx_done` wins.
- **RETRY**: if `attempts` ≤ `MAX_RETRIES`, go to START with the same byte. Otherwise go to RESULT with `ok`=0.
- **RESULT**: `done`=1 for exactly one cycle, then IDLE with `cmd_ready`=1 on the following cycle. The error flags and `attempts` hold until the next accept.
- `rx_done` outside WAIT_RESP is ignored, which drops stale or echoed bytes.
- `cmd_valid` while `cmd_ready`=0 is ignored and has no queueing.
- Reset mid-operation aborts immediately: `tx_start` drops, no `done` pulse is issued, and the block returns to IDLE.

## Timing
- Accept in cycle N → `tx_start`=1 in cycle N+1.
- A 0-cycle UART that acknowledges immediately gives `done` no earlier than accept+4 cycles.
- Timeout fires exactly `TIMEOUT_CYCLES` cycles after entry to WAIT_RESP.
- Counter widths are `$clog2(param+1)`. Counters saturate and never wrap.
- Worst-case command duration is (`MAX_RETRIES`+1) × (busy wait + frame + `TIMEOUT_CYCLES`).

## Configuration
- `UART_CMD_LINK_HAMMING_EN` defined:
  - `tx_data` = {1'b1, hamming(`cmd_data[3:0]`)}, and `cmd_data[7:4]` is ignored.
  - Parity bits: p1=d0^d1^d3, p2=d0^d2^d3, p3=d1^d2^d3.
  - Code word = {d3,d2,d1,p3,d0,p2,p1}.
- Not defined: `tx_data` = `cmd_data` verbatim.

## Structure
- Shared package `link_pkg` holds:
  - the state encoding (IDLE, START, SENDING, WAIT_RESP, RETRY, RESULT);
  - the default `ACK_BYTE` 8'h3C;
  - the command constants TURN_ON 4'h6, TURN_OFF 4'hD, TOGGLE 8'h9D.
- Sub-module `hamming_7_4_encoder` (combinational) is instantiated only under the macro.

## Test plan
- Macro off, command 8'h9D. UART model raises `tx_busy` 2 cycles after `tx_start`, holds it 480 cycles, then returns `rx_data`=8'h3C. Expect: `tx_data`=8'h9D, `done` with `ok`=1, `attempts`=1.
- No response, `MAX_RETRIES`=3. Expect: 4 transmissions, `done` with `ok`=0, `err_timeout`=1, `attempts`=4. Each WAIT_RESP lasts exactly 48000 cycles.
- First response is 8'h55, second is 8'h3C. Expect: `ok`=1, `attempts`=2. `err_nack` stays 1 from the failed attempt until the next accept.
- Correct ACK byte arrives with `rx_parity_error`=1. Expect: treated as NACK and the byte is retransmitted. An `rx_done` pulse injected during SENDING is ignored.
- Macro on, command 8'hF6. Expect: `tx_data`=8'hB3.
- Deassert `reset` during WAIT_RESP. Expect: all outputs 0 and no `done` pulse. `cmd_ready`=1 on the cycle after release, and a new command is accepted normally.
